// File: rtl/dram_stream_loader.sv
// dram_stream_loader
// Streams words into consecutive data-memory addresses (load) or reads an
// address window back out as a stream (dump) over a single memory port.
// Dump reads are credit-limited so every in-flight word has a FIFO slot.
module dram_stream_loader #(
    parameter int unsigned DATA_W     = 8,
    parameter int unsigned ADDR_W     = 16,
    parameter int unsigned RD_LAT     = 1,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic              clka,
    input  logic              rst_n,
    input  logic              start,
    input  logic              mode,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W:0]   length,
    input  logic              abort,
    input  logic [DATA_W-1:0] s_data,
    input  logic              s_valid,
    output logic              s_ready,
    output logic [DATA_W-1:0] m_data,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_re,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy,
    output logic              done
);

    localparam int unsigned PW = $clog2(FIFO_DEPTH);

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        DUMP,
        DONE
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] base_q;
    logic [ADDR_W:0]   len_q;
    logic [ADDR_W:0]   cnt_q;      // load: accepted words / offset; dump: issued reads
    logic [ADDR_W:0]   pop_q;      // dump: words popped from the FIFO
    logic [RD_LAT-1:0] tag_q;      // valid tags travelling alongside outstanding reads

    logic [DATA_W-1:0] fifo_mem [FIFO_DEPTH];
    logic [PW-1:0]     wr_ptr_q, rd_ptr_q;
    logic [PW:0]       fifo_cnt_q;

    logic              fire_start;
    logic              push, pop;
    int unsigned       inflight;

    // FIFO status and head; head is forced to zero while empty
    assign m_valid   = (fifo_cnt_q != '0);
    assign m_data    = m_valid ? fifo_mem[rd_ptr_q] : '0;
    assign mem_wdata = s_data;
    assign push      = tag_q[RD_LAT-1];

    // count reads still travelling through the memory pipeline
    always_comb begin
        inflight = 0;
        for (int unsigned i = 0; i < RD_LAT; i++) begin
            inflight += 32'(tag_q[i]);
        end
    end

    // next-state and combinational outputs; abort overrides everything
    always_comb begin
        state_d    = state_q;
        fire_start = 1'b0;
        s_ready    = 1'b0;
        mem_we     = 1'b0;
        mem_re     = 1'b0;
        mem_addr   = '0;
        pop        = 1'b0;
        busy       = (state_q != IDLE);
        done       = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    fire_start = 1'b1;
                    if (length == '0) begin
                        state_d = DONE;
                    end else if (mode) begin
                        state_d = DUMP;
                    end else begin
                        state_d = LOAD;
                    end
                end
            end
            LOAD: begin
                s_ready  = (cnt_q < len_q);
                mem_addr = base_q + cnt_q[ADDR_W-1:0];
                mem_we   = s_valid & s_ready;
                if (mem_we && (cnt_q == len_q - 1'b1)) begin
                    state_d = DONE;
                end
            end
            DUMP: begin
                mem_addr = base_q + cnt_q[ADDR_W-1:0];
                mem_re   = (cnt_q < len_q) && ((inflight + 32'(fifo_cnt_q)) < FIFO_DEPTH);
                pop      = m_valid & m_ready;
                if (pop && (pop_q == len_q - 1'b1)) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        if (abort) begin
            state_d    = IDLE;
            fire_start = 1'b0;
            s_ready    = 1'b0;
            mem_we     = 1'b0;
            mem_re     = 1'b0;
            pop        = 1'b0;
            done       = 1'b0;
        end
    end

    // state register
    always_ff @(posedge clka or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // latched operation parameters and progress counters
    always_ff @(posedge clka or negedge rst_n) begin
        if (!rst_n) begin
            base_q <= '0;
            len_q  <= '0;
            cnt_q  <= '0;
            pop_q  <= '0;
        end else if (fire_start) begin
            base_q <= base_addr;
            len_q  <= length;
            cnt_q  <= '0;
            pop_q  <= '0;
        end else begin
            if (mem_we || mem_re) begin
                cnt_q <= cnt_q + 1'b1;
            end
            if (pop) begin
                pop_q <= pop_q + 1'b1;
            end
        end
    end

    // read-tag shift register; flushing on abort discards late memory data
    always_ff @(posedge clka or negedge rst_n) begin
        if (!rst_n) begin
            tag_q <= '0;
        end else if (abort) begin
            tag_q <= '0;
        end else begin
            tag_q[0] <= mem_re;
            for (int unsigned i = 1; i < RD_LAT; i++) begin
                tag_q[i] <= tag_q[i-1];
            end
        end
    end

    // FIFO pointers and occupancy
    always_ff @(posedge clka or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            fifo_cnt_q <= '0;
        end else if (abort) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            fifo_cnt_q <= '0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            case ({push, pop})
                2'b10:   fifo_cnt_q <= fifo_cnt_q + 1'b1;
                2'b01:   fifo_cnt_q <= fifo_cnt_q - 1'b1;
                default: fifo_cnt_q <= fifo_cnt_q;
            endcase
        end
    end

    // FIFO storage, written with tagged read data
    always_ff @(posedge clka) begin
        if (push) begin
            fifo_mem[wr_ptr_q] <= mem_rdata;
        end
    end

endmodule

// File: tb/tb_dram_stream_loader.sv
// Testbench for dram_stream_loader (RD_LAT=2, FIFO_DEPTH=4).
// Directed steps in one initial block; writes and dump words go through
// scoreboard queues checked by a negedge monitor.
module tb_dram_stream_loader;

    localparam int DW    = 8;
    localparam int AW    = 16;
    localparam int LAT   = 2;
    localparam int DEPTH = 4;

    logic          clka;
    logic          rst_n;
    logic          start;
    logic          mode;
    logic [AW-1:0] base_addr;
    logic [AW:0]   length;
    logic          abort;
    logic [DW-1:0] s_data;
    logic          s_valid;
    logic          s_ready;
    logic [DW-1:0] m_data;
    logic          m_valid;
    logic          m_ready;
    logic [AW-1:0] mem_addr;
    logic          mem_we;
    logic [DW-1:0] mem_wdata;
    logic          mem_re;
    logic [DW-1:0] mem_rdata;
    logic          busy;
    logic          done;

    dram_stream_loader #(
        .DATA_W     (DW),
        .ADDR_W     (AW),
        .RD_LAT     (LAT),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clka      (clka),
        .rst_n     (rst_n),
        .start     (start),
        .mode      (mode),
        .base_addr (base_addr),
        .length    (length),
        .abort     (abort),
        .s_data    (s_data),
        .s_valid   (s_valid),
        .s_ready   (s_ready),
        .m_data    (m_data),
        .m_valid   (m_valid),
        .m_ready   (m_ready),
        .mem_addr  (mem_addr),
        .mem_we    (mem_we),
        .mem_wdata (mem_wdata),
        .mem_re    (mem_re),
        .mem_rdata (mem_rdata),
        .busy      (busy),
        .done      (done)
    );

    initial clka = 1'b0;
    always #5 clka = ~clka;

    // memory model: contents preloaded with addr[7:0], two-cycle read latency
    logic [DW-1:0] rd_p0, rd_p1;
    always @(posedge clka) begin
        rd_p0 <= mem_re ? mem_addr[7:0] : 8'hEE;
        rd_p1 <= rd_p0;
    end
    assign mem_rdata = rd_p1;

    typedef struct {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } wr_t;

    wr_t           exp_wr[$];
    logic [DW-1:0] exp_rd[$];

    int errors = 0;
    int checks = 0;
    int rd_issued = 0;
    int rd_popped = 0;
    int base_cr = 0;
    logic stalled_prev = 1'b0;
    logic [DW-1:0] held = '0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clka);
        #1;
    endtask

    task automatic exp_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
        wr_t w;
        w.addr = a;
        w.data = d;
        exp_wr.push_back(w);
    endtask

    // monitor: scoreboard compares, credit limit, exclusion, stall stability
    always @(negedge clka) begin
        wr_t           w;
        logic [DW-1:0] d;
        if (!rst_n) begin
            stalled_prev = 1'b0;
        end else begin
            chk1("mutex", mem_we & mem_re, 1'b0);
            if (mem_we) begin
                if (exp_wr.size() == 0) begin
                    chk1("wr_spurious", mem_we, 1'b0);
                end else begin
                    w = exp_wr.pop_front();
                    chk("wr_addr", 32'(mem_addr), 32'(w.addr));
                    chk("wr_data", 32'(mem_wdata), 32'(w.data));
                end
            end
            if (mem_re) begin
                chk1("credit", (rd_issued - rd_popped - base_cr) < DEPTH, 1'b1);
                rd_issued++;
            end
            if (stalled_prev) begin
                chk1("stall_valid", m_valid, 1'b1);
                chk("stall_data", 32'(m_data), 32'(held));
            end
            if (m_valid && m_ready) begin
                if (exp_rd.size() == 0) begin
                    chk1("rd_spurious", m_valid, 1'b0);
                end else begin
                    d = exp_rd.pop_front();
                    chk("rd_data", 32'(m_data), 32'(d));
                end
                rd_popped++;
            end
            stalled_prev = m_valid && !m_ready;
            held         = m_data;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [3:0] pat;
        logic       got_done;
        int         ev0;
        int         pops0;

        rst_n = 1'b0; start = 1'b0; mode = 1'b0; base_addr = '0; length = '0;
        abort = 1'b0; s_data = '0; s_valid = 1'b0; m_ready = 1'b1;
        #2;
        chk1("rst_busy", busy, 1'b0);
        chk1("rst_done", done, 1'b0);
        chk1("rst_sready", s_ready, 1'b0);
        chk1("rst_mvalid", m_valid, 1'b0);
        chk1("rst_we", mem_we, 1'b0);
        chk1("rst_re", mem_re, 1'b0);
        chk("rst_addr", 32'(mem_addr), 32'h0);
        chk("rst_mdata", 32'(m_data), 32'h0);
        tick();
        tick();
        rst_n = 1'b1;
        tick();

        // load of 5 words wrapping past the top address; start while busy ignored
        exp_write(16'hFFFE, 8'd10);
        exp_write(16'hFFFF, 8'd11);
        exp_write(16'h0000, 8'd12);
        exp_write(16'h0001, 8'd13);
        exp_write(16'h0002, 8'd14);
        mode = 1'b0; base_addr = 16'hFFFE; length = 17'd5;
        s_valid = 1'b1; s_data = 8'd10; start = 1'b1;
        tick();
        start = 1'b0;
        chk1("ld_busy", busy, 1'b1);
        for (int i = 0; i < 5; i++) begin
            chk1("ld_we", mem_we, 1'b1);
            chk1("ld_sready", s_ready, 1'b1);
            if (i == 2) begin
                start = 1'b1; mode = 1'b1; base_addr = 16'h1234; length = 17'd2;
            end
            tick();
            start = 1'b0;
            s_data = 8'(11 + i);
        end
        chk1("ld_done", done, 1'b1);
        chk1("ld_done_sready", s_ready, 1'b0);
        chk1("ld_done_we", mem_we, 1'b0);
        s_valid = 1'b0;
        tick();
        chk1("ld_done_pulse", done, 1'b0);
        chk1("ld_idle", busy, 1'b0);
        chk("ld_sb_empty", 32'(exp_wr.size()), 32'd0);

        // dump of 8 words at 0x0100, m_ready held high
        base_cr = rd_issued - rd_popped;
        for (int k = 0; k < 8; k++) exp_rd.push_back(8'(k));
        mode = 1'b1; base_addr = 16'h0100; length = 17'd8; m_ready = 1'b1; start = 1'b1;
        tick();
        start = 1'b0;
        chk1("dp_busy", busy, 1'b1);
        chk1("dp_re_first", mem_re, 1'b1);
        chk("dp_addr_first", 32'(mem_addr), 32'h0100);
        chk1("dp_nvalid_n1", m_valid, 1'b0);
        tick();
        chk1("dp_nvalid_n2", m_valid, 1'b0);
        tick();
        chk1("dp_nvalid_n3", m_valid, 1'b0);
        tick();
        for (int k = 0; k < 8; k++) begin
            chk1("dp_valid", m_valid, 1'b1);
            chk("dp_word", 32'(m_data), 32'(k));
            tick();
        end
        chk1("dp_done", done, 1'b1);
        tick();
        chk1("dp_done_pulse", done, 1'b0);
        chk1("dp_idle", busy, 1'b0);
        chk("dp_sb_empty", 32'(exp_rd.size()), 32'd0);

        // dump under back-pressure, m_ready pattern 1,0,0,1
        base_cr = rd_issued - rd_popped;
        for (int k = 0; k < 10; k++) exp_rd.push_back(8'(k));
        base_addr = 16'h0200; length = 17'd10; start = 1'b1;
        tick();
        start = 1'b0;
        pat = 4'b1001;
        got_done = 1'b0;
        for (int c = 0; c < 200 && !got_done; c++) begin
            m_ready = pat[c % 4];
            if (done) got_done = 1'b1;
            else tick();
        end
        chk1("bp_done", got_done, 1'b1);
        chk("bp_sb_empty", 32'(exp_rd.size()), 32'd0);
        m_ready = 1'b1;
        tick();
        chk1("bp_idle", busy, 1'b0);

        // zero length in both modes
        ev0 = rd_issued;
        for (int md = 0; md < 2; md++) begin
            mode = md[0]; base_addr = 16'h0040; length = '0; start = 1'b1;
            tick();
            start = 1'b0;
            chk1("zl_done", done, 1'b1);
            chk1("zl_busy", busy, 1'b1);
            chk1("zl_we", mem_we, 1'b0);
            chk1("zl_re", mem_re, 1'b0);
            tick();
            chk1("zl_done_pulse", done, 1'b0);
            chk1("zl_idle", busy, 1'b0);
        end
        chk("zl_no_reads", 32'(rd_issued - ev0), 32'd0);

        // abort a 100-word dump at word 37
        base_cr = rd_issued - rd_popped;
        pops0 = rd_popped;
        for (int k = 0; k < 100; k++) exp_rd.push_back(8'(k));
        mode = 1'b1; base_addr = 16'h0300; length = 17'd100; m_ready = 1'b1; start = 1'b1;
        tick();
        start = 1'b0;
        for (int c = 0; c < 300 && (rd_popped - pops0) < 37; c++) tick();
        chk("ab_reach37", 32'(rd_popped - pops0), 32'd37);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        exp_rd.delete();
        chk1("ab_idle", busy, 1'b0);
        chk1("ab_mvalid", m_valid, 1'b0);
        chk1("ab_nodone", done, 1'b0);
        for (int c = 0; c < 4; c++) begin
            tick();
            chk1("ab_late_mvalid", m_valid, 1'b0);
            chk1("ab_late_done", done, 1'b0);
        end

        // normal 3-word load after the abort
        exp_write(16'h0010, 8'hA0);
        exp_write(16'h0011, 8'hA1);
        exp_write(16'h0012, 8'hA2);
        mode = 1'b0; base_addr = 16'h0010; length = 17'd3;
        s_valid = 1'b1; s_data = 8'hA0; start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk1("al_we", mem_we, 1'b1);
            tick();
            s_data = 8'(8'hA1 + i);
        end
        chk1("al_done", done, 1'b1);
        s_valid = 1'b0;
        tick();
        chk1("al_idle", busy, 1'b0);
        chk("al_sb_empty", 32'(exp_wr.size()), 32'd0);

        // asynchronous reset in the middle of a load
        exp_write(16'h0050, 8'hB0);
        exp_write(16'h0051, 8'hB1);
        mode = 1'b0; base_addr = 16'h0050; length = 17'd6;
        s_valid = 1'b1; s_data = 8'hB0; start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        s_data = 8'hB1;
        tick();
        s_data = 8'hB2;
        rst_n = 1'b0;
        #1;
        chk1("mr_busy", busy, 1'b0);
        chk1("mr_sready", s_ready, 1'b0);
        chk1("mr_we", mem_we, 1'b0);
        chk1("mr_re", mem_re, 1'b0);
        chk1("mr_done", done, 1'b0);
        chk1("mr_mvalid", m_valid, 1'b0);
        chk("mr_addr", 32'(mem_addr), 32'h0);
        chk("mr_mdata", 32'(m_data), 32'h0);
        s_valid = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        chk1("mr_idle", busy, 1'b0);
        chk("mr_sb_empty", 32'(exp_wr.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
